// File: rtl/fetch_pc_if.sv
// Instruction-memory fetch port between the fetch/PC stage and instruction memory.
// The fetch stage is the master: it raises the request and address, memory answers with data/ready.
interface fetch_pc_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_pc.sv
// Fetch and PC sequencing stage: IDLE/FETCH/EXEC loop, next-PC selection from execute/control,
// and interrupt arbitration where pc[31] marks supervisor mode.
module fetch_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pc_src,
  input  logic        branch,
  input  logic [31:0] conba,
  input  logic [31:0] data_a,
  input  logic        stall,
  input  logic        irq,
  fetch_pc_if.master  imem,
  output logic [31:0] pc,
  output logic [31:0] instruct,
  output logic        inst_valid,
  output logic        irq_take
);

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP    = 32'h8000_0004;
  localparam logic [31:0] XADR     = 32'h8000_0008;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instruct_q, instruct_d;
  logic        irq_pend_q, irq_pend_d;

  logic        exec_s;
  logic        irq_take_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] sel_pc_s;
  logic [31:0] next_pc_s;

  assign exec_s = (state_q == S_EXEC);

  // Exceptions (src 4/5) win over interrupts; kernel mode never takes them.
  assign irq_take_s = exec_s & ~stall & irq_pend_q & ~pc_q[31]
                    & (pc_src != 3'd4) & (pc_src != 3'd5);

  // Next-PC select; the increment never carries into the supervisor bit.
  always_comb begin
    pc_plus4_s = {pc_q[31], pc_q[30:0] + 31'd4};
    sel_pc_s   = pc_plus4_s;
    case (pc_src)
      3'd1:    sel_pc_s = branch ? conba : pc_plus4_s;
      3'd2:    sel_pc_s = {pc_q[31:28], instruct_q[25:0], 2'b00};
      3'd3:    sel_pc_s = {data_a[31] & pc_q[31], data_a[30:0]};
      3'd4:    sel_pc_s = ILLOP;
      3'd5:    sel_pc_s = XADR;
      default: sel_pc_s = pc_plus4_s;
    endcase
    next_pc_s = irq_take_s ? ILLOP : sel_pc_s;
  end

  // State machine next-state, PC and instruction capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instruct_d = instruct_q;
    irq_pend_d = irq | (irq_pend_q & ~irq_take_s);
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.imem_ready) begin
          state_d    = S_EXEC;
          instruct_d = imem.imem_rdata;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          state_d = S_FETCH;
          pc_d    = next_pc_s;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instruct_q <= 32'h0000_0000;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instruct_q <= instruct_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign pc             = pc_q;
  assign instruct       = instruct_q;
  assign inst_valid     = exec_s;
  assign irq_take       = irq_take_s;
  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed table-driven bench for fetch_pc: one record per instruction (fetch waits, execute
// inputs, expected PC/irq_take/next PC), plus hand sequences for stall and mid-fetch reset.
module tb_fetch_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pc_src;
  logic        branch;
  logic [31:0] conba;
  logic [31:0] data_a;
  logic        stall;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] instruct;
  logic        inst_valid;
  logic        irq_take;

  int checks = 0;
  int errors = 0;

  fetch_pc_if bus ();

  fetch_pc dut (
    .clk        (clk),
    .reset      (reset),
    .pc_src     (pc_src),
    .branch     (branch),
    .conba      (conba),
    .data_a     (data_a),
    .stall      (stall),
    .irq        (irq),
    .imem       (bus.master),
    .pc         (pc),
    .instruct   (instruct),
    .inst_valid (inst_valid),
    .irq_take   (irq_take)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic [2:0]  src;
    logic        br;
    logic [31:0] cb;
    logic [31:0] da;
    logic        irq_in;
    logic [31:0] exp_pc;
    logic        exp_take;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int w, logic [31:0] rd, logic [2:0] s, logic br, logic [31:0] cb,
                              logic [31:0] da, logic ir, logic [31:0] ep, logic et,
                              logic [31:0] en);
    vec_t v;
    v.waits = w; v.rdata = rd; v.src = s; v.br = br; v.cb = cb; v.da = da;
    v.irq_in = ir; v.exp_pc = ep; v.exp_take = et; v.exp_next = en;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge with the DUT in FETCH; leaves it in the next FETCH.
  task automatic run_instr(int idx, vec_t v);
    chk1($sformatf("v%0d fetch req", idx), bus.imem_req, 1'b1);
    chk1($sformatf("v%0d fetch valid", idx), inst_valid, 1'b0);
    chk32($sformatf("v%0d fetch pc", idx), pc, v.exp_pc);
    chk32($sformatf("v%0d imem_addr", idx), bus.imem_addr, v.exp_pc);
    for (int i = 0; i < v.waits; i++) begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = 32'hFFFF_FFFF;
      tick();
      chk1($sformatf("v%0d wait%0d req", idx, i), bus.imem_req, 1'b1);
      chk1($sformatf("v%0d wait%0d valid", idx, i), inst_valid, 1'b0);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = v.rdata;
    tick();
    // Ready/data during EXEC must be ignored.
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    pc_src = v.src; branch = v.br; conba = v.cb; data_a = v.da; irq = v.irq_in;
    #1;
    chk1($sformatf("v%0d exec valid", idx), inst_valid, 1'b1);
    chk1($sformatf("v%0d exec req", idx), bus.imem_req, 1'b0);
    chk32($sformatf("v%0d exec pc", idx), pc, v.exp_pc);
    chk32($sformatf("v%0d instruct", idx), instruct, v.rdata);
    chk1($sformatf("v%0d irq_take", idx), irq_take, v.exp_take);
    tick();
    irq = 1'b0; pc_src = 3'd0; branch = 1'b0;
    bus.imem_ready = 1'b0;
    chk32($sformatf("v%0d next pc", idx), pc, v.exp_next);
  endtask

  initial begin
    reset = 1'b1; pc_src = 3'd0; branch = 1'b0; conba = 32'h0; data_a = 32'h0;
    stall = 1'b0; irq = 1'b0;
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_0000;

    //              waits rdata          src   br  conba          data_a         irq   pc             take  next
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h8000_0000, 1'b0, 32'h8000_0004));
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h8000_0004, 1'b0, 32'h8000_0008));
    vecs.push_back(mk(0, 32'h1234_0006, 3'd6, 1'b0, 32'h0,        32'h0,        1'b0, 32'h8000_0008, 1'b0, 32'h8000_000C));
    vecs.push_back(mk(0, 32'hA5A5_0003, 3'd3, 1'b0, 32'h0,        32'h0040_0000, 1'b0, 32'h8000_000C, 1'b0, 32'h0040_0000));
    vecs.push_back(mk(2, 32'h1000_0001, 3'd1, 1'b1, 32'h0040_0020, 32'h0,        1'b0, 32'h0040_0000, 1'b0, 32'h0040_0020));
    vecs.push_back(mk(0, 32'h0000_0003, 3'd3, 1'b0, 32'h0,        32'h0040_0000, 1'b0, 32'h0040_0020, 1'b0, 32'h0040_0000));
    vecs.push_back(mk(2, 32'h1000_0002, 3'd1, 1'b0, 32'h0040_0020, 32'h0,        1'b0, 32'h0040_0000, 1'b0, 32'h0040_0004));
    vecs.push_back(mk(1, 32'h0000_0013, 3'd3, 1'b0, 32'h0,        32'h0040_0010, 1'b0, 32'h0040_0004, 1'b0, 32'h0040_0010));
    vecs.push_back(mk(0, 32'h0810_0004, 3'd2, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0040_0010, 1'b0, 32'h0040_0010));
    vecs.push_back(mk(0, 32'h0000_0023, 3'd3, 1'b0, 32'h0,        32'h8000_1000, 1'b0, 32'h0040_0010, 1'b0, 32'h0000_1000));
    vecs.push_back(mk(0, 32'h7777_0007, 3'd7, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_1000, 1'b0, 32'h0000_1004));
    vecs.push_back(mk(0, 32'h4444_0004, 3'd4, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0000_1004, 1'b0, 32'h8000_0004));
    vecs.push_back(mk(0, 32'h5555_0005, 3'd5, 1'b0, 32'h0,        32'h0,        1'b0, 32'h8000_0004, 1'b0, 32'h8000_0008));
    vecs.push_back(mk(0, 32'h0000_0033, 3'd3, 1'b0, 32'h0,        32'hFFFF_FFFC, 1'b0, 32'h8000_0008, 1'b0, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'hFFFF_FFFC, 1'b0, 32'h8000_0000));
    vecs.push_back(mk(0, 32'h0000_0043, 3'd3, 1'b0, 32'h0,        32'h0040_0000, 1'b0, 32'h8000_0000, 1'b0, 32'h0040_0000));
    // irq pulse in user mode: taken on the following EXEC.
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0040_0000, 1'b0, 32'h0040_0004));
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0040_0004, 1'b1, 32'h8000_0004));
    // irq in kernel mode: held pending until jr to user.
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h8000_0004, 1'b0, 32'h8000_0008));
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h8000_0008, 1'b0, 32'h8000_000C));
    vecs.push_back(mk(0, 32'h0000_0053, 3'd3, 1'b0, 32'h0,        32'h0040_0100, 1'b0, 32'h8000_000C, 1'b0, 32'h0040_0100));
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0040_0100, 1'b1, 32'h8000_0004));
    // Exception beats interrupt; pending survives and is taken later over a branch.
    vecs.push_back(mk(0, 32'h0000_0063, 3'd3, 1'b0, 32'h0,        32'h0040_0200, 1'b0, 32'h8000_0004, 1'b0, 32'h0040_0200));
    vecs.push_back(mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0040_0200, 1'b0, 32'h0040_0204));
    vecs.push_back(mk(0, 32'h0000_0000, 3'd5, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0040_0204, 1'b0, 32'h8000_0008));
    vecs.push_back(mk(0, 32'h0000_0073, 3'd3, 1'b0, 32'h0,        32'h0040_0300, 1'b0, 32'h8000_0008, 1'b0, 32'h0040_0300));
    vecs.push_back(mk(0, 32'h0000_0001, 3'd1, 1'b1, 32'h0040_0400, 32'h0,        1'b0, 32'h0040_0300, 1'b1, 32'h8000_0004));

    tick();
    tick();
    chk32("reset pc", pc, 32'h8000_0000);
    chk32("reset instruct", instruct, 32'h0000_0000);
    chk1("reset inst_valid", inst_valid, 1'b0);
    chk1("reset imem_req", bus.imem_req, 1'b0);
    chk1("reset irq_take", irq_take, 1'b0);
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    #1;
    chk1("idle imem_req", bus.imem_req, 1'b0);
    tick();

    for (int k = 0; k < vecs.size(); k++) begin
      run_instr(k, vecs[k]);
    end

    // Two stall cycles in EXEC at kernel pc 0x80000004; irq raised meanwhile.
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    tick();
    bus.imem_rdata = 32'hBAD0_BAD0;
    stall = 1'b1;
    irq = 1'b1;
    #1;
    chk1("stall irq_take", irq_take, 1'b0);
    for (int s = 0; s < 2; s++) begin
      tick();
      irq = 1'b0;
      chk32($sformatf("stall%0d pc", s), pc, 32'h8000_0004);
      chk32($sformatf("stall%0d instruct", s), instruct, 32'h1234_5678);
      chk1($sformatf("stall%0d inst_valid", s), inst_valid, 1'b1);
    end
    stall = 1'b0;
    bus.imem_ready = 1'b0;
    tick();
    chk32("post stall pc", pc, 32'h8000_0008);
    chk1("post stall inst_valid", inst_valid, 1'b0);

    // Reset in the middle of FETCH with ready high; pending irq must be cleared.
    tick();
    reset = 1'b1;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk32("midreset pc", pc, 32'h8000_0000);
    chk32("midreset instruct", instruct, 32'h0000_0000);
    chk1("midreset inst_valid", inst_valid, 1'b0);
    chk1("midreset imem_req", bus.imem_req, 1'b0);
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    tick();
    run_instr(100, mk(0, 32'h0000_0083, 3'd3, 1'b0, 32'h0, 32'h0040_0000, 1'b0, 32'h8000_0000, 1'b0, 32'h0040_0000));
    run_instr(101, mk(0, 32'h0000_0000, 3'd0, 1'b0, 32'h0, 32'h0,        1'b0, 32'h0040_0000, 1'b0, 32'h0040_0004));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
